// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake state, data word and
// arbiter FSM encoding.
package cpu_types_pkg;

    localparam int WORD_W_DEF = 32;

    typedef logic [WORD_W_DEF-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: returns the first set request at or above ptr,
// wrapping modulo N.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [(1<<IW)-1:0] req_pad_s;
    logic [IW:0]        sum_s;
    logic [IW-1:0]      cand_s;
    logic               hit_s;
    logic               found_s;
    logic [IW-1:0]      idx_s;

    // Scan N candidates starting at ptr; the first hit wins.
    always_comb begin
        req_pad_s        = '0;
        req_pad_s[N-1:0] = req;
        found_s          = 1'b0;
        idx_s            = '0;
        sum_s            = '0;
        cand_s           = '0;
        hit_s            = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum_s   = {1'b0, ptr} + (IW+1)'(k);
            cand_s  = (sum_s >= N_W) ? IW'(sum_s - N_W) : sum_s[IW-1:0];
            hit_s   = ~found_s & req_pad_s[cand_s];
            idx_s   = hit_s ? cand_s : idx_s;
            found_s = found_s | hit_s;
        end
    end

    assign found = found_s;
    assign idx   = idx_s;

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates per-CPU instruction and data requests onto a single RAM port.
// Data beats instruction; CPUs are served round-robin within each class.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS*WORD_W-1:0] iaddr,
    input  logic [CPUS*WORD_W-1:0] daddr,
    input  logic [CPUS*WORD_W-1:0] dstore,
    output logic [CPUS-1:0]        iwait,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS*WORD_W-1:0] iload,
    output logic [CPUS*WORD_W-1:0] dload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic [1:0]             ramstate
);

    localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;

    arb_state_t    state_q, state_d;
    logic [PW-1:0] grant_q, grant_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] rr_next_s;
    logic [PW-1:0] d_idx_s, i_idx_s;
    logic          d_found_s, i_found_s;
    logic [CPUS-1:0] d_req_s;
    ramstate_t     ramstate_s;

    assign ramstate_s = ramstate_t'(ramstate);
    assign d_req_s    = dREN | dWEN;

    rr_picker #(.N(CPUS), .IW(PW)) u_dpick (
        .req   (d_req_s),
        .ptr   (rr_ptr_q),
        .found (d_found_s),
        .idx   (d_idx_s)
    );

    rr_picker #(.N(CPUS), .IW(PW)) u_ipick (
        .req   (iREN),
        .ptr   (rr_ptr_q),
        .found (i_found_s),
        .idx   (i_idx_s)
    );

    // Read data is broadcast to every requestor; the wait bits qualify it.
    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

    // With one CPU this always yields zero, so the pointer stays constant.
    assign rr_next_s = (grant_q == PW'(CPUS-1)) ? '0 : grant_q + 1'b1;

    // Next-state, grant bookkeeping and all RAM/wait outputs.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        iwait    = '1;
        dwait    = '1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            IDLE: begin
                if (d_found_s) begin
                    state_d = DGRANT;
                    grant_d = d_idx_s;
                end else if (i_found_s) begin
                    state_d = IGRANT;
                    grant_d = i_idx_s;
                end else begin
                    state_d = IDLE;
                end
            end
            DGRANT: begin
                ramaddr  = daddr[int'(grant_q)*WORD_W +: WORD_W];
                ramstore = dstore[int'(grant_q)*WORD_W +: WORD_W];
                ramWEN   = dWEN[grant_q];
                ramREN   = dREN[grant_q] & ~dWEN[grant_q];
                // A withdrawn request aborts silently, even if ACCESS arrives.
                if (!d_req_s[grant_q]) begin
                    state_d = IDLE;
                end else if (ramstate_s == ACCESS) begin
                    dwait[grant_q] = 1'b0;
                    state_d        = IDLE;
                    rr_ptr_d       = rr_next_s;
                end else begin
                    state_d = DGRANT;
                end
            end
            IGRANT: begin
                ramaddr = iaddr[int'(grant_q)*WORD_W +: WORD_W];
                ramREN  = 1'b1;
                if (!iREN[grant_q]) begin
                    state_d = IDLE;
                end else if (ramstate_s == ACCESS) begin
                    iwait[grant_q] = 1'b0;
                    state_d        = IDLE;
                    rr_ptr_d       = rr_next_s;
                end else begin
                    state_d = IGRANT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant FSM state, granted CPU and round-robin pointer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
